// File: rtl/split_n_opc_dispatch_pkg.sv
// Shared opcodes and FSM state encoding for the
// opcode-steered req/ack dispatcher.
package split_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    RTZ,
    ERR_HOLD
  } split_st_t;

endpackage

// File: rtl/split_n_opc_dispatch_if.sv
// Upstream/downstream handshake bundle of the
// dispatcher; slave is the dispatcher side.
interface split_n_opc_dispatch_if #(
  parameter int N_CH  = 2,
  parameter int OPC_W = 7
) ();

  logic              req_in;
  logic [OPC_W-1:0]  opcode;
  logic              ack_out;
  logic [N_CH-1:0]   req_out;
  logic [N_CH-1:0]   ack_in;
  logic [N_CH-1:0]   sel_out;
  logic              err_opc;
  logic              timeout;

  modport master (
    output req_in,
    output opcode,
    output ack_in,
    input  ack_out,
    input  req_out,
    input  sel_out,
    input  err_opc,
    input  timeout
  );

  modport slave (
    input  req_in,
    input  opcode,
    input  ack_in,
    output ack_out,
    output req_out,
    output sel_out,
    output err_opc,
    output timeout
  );

endinterface

// File: rtl/split_n_opc_dispatch_decode.sv
// Combinational opcode table matcher: lowest
// matching slice wins, broadcast selects all.
module split_opc_decode #(
  parameter int N_CH  = 2,
  parameter int OPC_W = 7,
  parameter logic [N_CH*OPC_W-1:0] OPC_TABLE = '0,
  parameter bit BCAST = 1'b0
) (
  input  logic [OPC_W-1:0] opcode,
  output logic [N_CH-1:0]  mask,
  output logic             hit
);

  always_comb begin
    mask = '0;
    hit  = 1'b0;
    if (BCAST) begin
      mask = '1;
      hit  = 1'b1;
    end else begin
      // descending scan so the lowest index overwrites
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (OPC_TABLE[i*OPC_W +: OPC_W] == opcode) begin
          mask    = '0;
          mask[i] = 1'b1;
          hit     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/split_n_opc_dispatch.sv
// Steers or forks one 4-phase request to N_CH
// channels by opcode and joins the acks back.
module split_n_opc_dispatch
  import split_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int OPC_W = 7,
  parameter logic [N_CH*OPC_W-1:0] OPC_TABLE =
    {OPC_LOAD, OPC_STORE},
  parameter bit BCAST   = 1'b0,
  parameter int TMO_CYC = 1024
) (
  input logic clk,
  input logic rst,
  split_n_opc_dispatch_if.slave bus
);

  localparam int CW =
    (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TMO_CYC);

  split_st_t st, st_nxt;

  logic [N_CH-1:0] mask;
  logic            hit;

  logic [N_CH-1:0] req_q, req_nxt;
  logic [N_CH-1:0] sel_q, sel_nxt;
  logic            ack_q, ack_nxt;
  logic            err_q, err_nxt;
  logic            tmo_q, tmo_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic            wait_st;

  split_opc_decode #(
    .N_CH      (N_CH),
    .OPC_W     (OPC_W),
    .OPC_TABLE (OPC_TABLE),
    .BCAST     (BCAST)
  ) u_dec (
    .opcode (bus.opcode),
    .mask   (mask),
    .hit    (hit)
  );

  assign wait_st = (st == REQ) || (st == RTZ);

  always_comb begin
    st_nxt  = st;
    req_nxt = req_q;
    sel_nxt = sel_q;
    ack_nxt = ack_q;
    err_nxt = 1'b0;
    unique case (st)
      IDLE: begin
        if (bus.req_in) begin
          if (hit) begin
            sel_nxt = mask;
            req_nxt = mask;
            st_nxt  = REQ;
          end else begin
            err_nxt = 1'b1;
            ack_nxt = 1'b1;
            st_nxt  = ERR_HOLD;
          end
        end
      end
      REQ: begin
        // an early req_in drop is ignored here
        if ((bus.ack_in & sel_q) == sel_q) begin
          ack_nxt = 1'b1;
          st_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (!bus.req_in) begin
          req_nxt = '0;
          st_nxt  = RTZ;
        end
      end
      RTZ: begin
        if ((bus.ack_in & sel_q) == '0) begin
          ack_nxt = 1'b0;
          sel_nxt = '0;
          st_nxt  = IDLE;
        end
      end
      ERR_HOLD: begin
        if (!bus.req_in) begin
          ack_nxt = 1'b0;
          st_nxt  = IDLE;
        end
      end
      default: begin
        st_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_nxt = cnt_q;
    tmo_nxt = tmo_q;
    if (st_nxt != st) begin
      cnt_nxt = '0;
    end else if (wait_st && (cnt_q != CMAX)) begin
      cnt_nxt = cnt_q + 1'b1;
    end
    // counter only reaches CMAX while waiting
    if ((TMO_CYC != 0) && (cnt_nxt == CMAX)) begin
      tmo_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      req_q <= '0;
      sel_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st    <= st_nxt;
      req_q <= req_nxt;
      sel_q <= sel_nxt;
      ack_q <= ack_nxt;
      err_q <= err_nxt;
      tmo_q <= tmo_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign bus.req_out = req_q;
  assign bus.sel_out = sel_q;
  assign bus.ack_out = ack_q;
  assign bus.err_opc = err_q;
  assign bus.timeout = tmo_q;

endmodule

// File: tb/tb_split_n_opc_dispatch.sv
// Bench for the opcode dispatcher: vector table,
// directed corner sequences and a random run.
module tb_split_n_opc_dispatch;
  import split_pkg::*;

  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] UNK = 7'b0110011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  split_n_opc_dispatch_if #(.N_CH(2), .OPC_W(7)) b2 ();
  split_n_opc_dispatch_if #(.N_CH(4), .OPC_W(7)) b4 ();
  split_n_opc_dispatch_if #(.N_CH(3), .OPC_W(7)) b3 ();

  split_n_opc_dispatch #(
    .N_CH(2), .OPC_W(7), .OPC_TABLE({LD, ST}),
    .BCAST(1'b0), .TMO_CYC(8)
  ) u2 (.clk(clk), .rst(rst), .bus(b2));

  split_n_opc_dispatch #(
    .N_CH(4), .OPC_W(7), .OPC_TABLE({4{ST}}),
    .BCAST(1'b1), .TMO_CYC(0)
  ) u4 (.clk(clk), .rst(rst), .bus(b4));

  split_n_opc_dispatch #(
    .N_CH(3), .OPC_W(7), .OPC_TABLE({LD, ST, ST}),
    .BCAST(1'b0), .TMO_CYC(1024)
  ) u3 (.clk(clk), .rst(rst), .bus(b3));

  // channel routing of u3, index = channel
  logic [6:0] tbl3 [3];

  typedef struct {
    logic       req;
    logic [6:0] opc;
    logic [1:0] ack;
    logic [1:0] x_req;
    logic       x_ack;
    logic [1:0] x_sel;
    logic       x_err;
  } vec_t;

  vec_t vt [19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_mask(
    input logic [6:0] o);
    for (int i = 0; i < 3; i++)
      if (tbl3[i] == o) return 3'(1 << i);
    return 3'b000;
  endfunction

  logic [2:0] m, nz, part;
  logic [6:0] opc;
  int r, d;

  initial begin
    tbl3[0] = ST;
    tbl3[1] = ST;
    tbl3[2] = LD;

    vt[0]  = '{1'b1, ST,  2'b00, 2'b01, 1'b0, 2'b01, 1'b0};
    vt[1]  = '{1'b1, LD,  2'b00, 2'b01, 1'b0, 2'b01, 1'b0};
    vt[2]  = '{1'b1, UNK, 2'b01, 2'b01, 1'b1, 2'b01, 1'b0};
    vt[3]  = '{1'b1, ST,  2'b01, 2'b01, 1'b1, 2'b01, 1'b0};
    vt[4]  = '{1'b0, ST,  2'b01, 2'b00, 1'b1, 2'b01, 1'b0};
    vt[5]  = '{1'b0, ST,  2'b01, 2'b00, 1'b1, 2'b01, 1'b0};
    vt[6]  = '{1'b0, ST,  2'b00, 2'b00, 1'b0, 2'b00, 1'b0};
    vt[7]  = '{1'b0, ST,  2'b00, 2'b00, 1'b0, 2'b00, 1'b0};
    vt[8]  = '{1'b1, LD,  2'b01, 2'b10, 1'b0, 2'b10, 1'b0};
    vt[9]  = '{1'b1, LD,  2'b01, 2'b10, 1'b0, 2'b10, 1'b0};
    vt[10] = '{1'b1, LD,  2'b00, 2'b10, 1'b0, 2'b10, 1'b0};
    vt[11] = '{1'b1, LD,  2'b10, 2'b10, 1'b1, 2'b10, 1'b0};
    vt[12] = '{1'b0, LD,  2'b11, 2'b00, 1'b1, 2'b10, 1'b0};
    vt[13] = '{1'b0, LD,  2'b01, 2'b00, 1'b0, 2'b00, 1'b0};
    vt[14] = '{1'b0, LD,  2'b00, 2'b00, 1'b0, 2'b00, 1'b0};
    vt[15] = '{1'b1, UNK, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1};
    vt[16] = '{1'b1, UNK, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0};
    vt[17] = '{1'b0, UNK, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0};
    vt[18] = '{1'b0, ST,  2'b00, 2'b00, 1'b0, 2'b00, 1'b0};

    b2.req_in = 1'b0; b2.opcode = '0; b2.ack_in = '0;
    b4.req_in = 1'b0; b4.opcode = '0; b4.ack_in = '0;
    b3.req_in = 1'b0; b3.opcode = '0; b3.ack_in = '0;

    step(); step();
    chk("rst_req2", 32'(b2.req_out), 0);
    chk("rst_ack2", 32'(b2.ack_out), 0);
    chk("rst_sel2", 32'(b2.sel_out), 0);
    chk("rst_err2", 32'(b2.err_opc), 0);
    chk("rst_tmo2", 32'(b2.timeout), 0);
    chk("rst_req4", 32'(b4.req_out), 0);
    chk("rst_req3", 32'(b3.req_out), 0);
    rst = 1'b0;
    step();

    // store / load / unknown vectors on 2 channels
    for (int i = 0; i < 19; i++) begin
      b2.req_in = vt[i].req;
      b2.opcode = vt[i].opc;
      b2.ack_in = vt[i].ack;
      step();
      chk($sformatf("v%0d_req", i),
          32'(b2.req_out), 32'(vt[i].x_req));
      chk($sformatf("v%0d_ack", i),
          32'(b2.ack_out), 32'(vt[i].x_ack));
      chk($sformatf("v%0d_sel", i),
          32'(b2.sel_out), 32'(vt[i].x_sel));
      chk($sformatf("v%0d_err", i),
          32'(b2.err_opc), 32'(vt[i].x_err));
      chk($sformatf("v%0d_tmo", i),
          32'(b2.timeout), 0);
    end

    // broadcast fork/join on 4 channels
    b4.opcode = UNK;
    b4.req_in = 1'b1;
    step();
    chk("bc_req", 32'(b4.req_out), 32'hf);
    chk("bc_err", 32'(b4.err_opc), 0);
    b4.ack_in = 4'b0111;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("bc_part_ack", 32'(b4.ack_out), 0);
    end
    chk("bc_no_tmo", 32'(b4.timeout), 0);
    b4.ack_in = 4'b1111;
    step();
    chk("bc_join", 32'(b4.ack_out), 1);
    b4.req_in = 1'b0;
    step();
    chk("bc_rtz_req", 32'(b4.req_out), 0);
    b4.ack_in = 4'b0000;
    step();
    chk("bc_rtz_ack", 32'(b4.ack_out), 0);
    chk("bc_rtz_sel", 32'(b4.sel_out), 0);

    // timeout after 8 cycles in REQ, late ack still completes
    b2.opcode = ST;
    b2.req_in = 1'b1;
    b2.ack_in = 2'b00;
    step();
    for (int k = 1; k < 8; k++) step();
    chk("tmo_before", 32'(b2.timeout), 0);
    step();
    chk("tmo_set", 32'(b2.timeout), 1);
    step(); step();
    chk("tmo_sticky", 32'(b2.timeout), 1);
    chk("tmo_wait_ack", 32'(b2.ack_out), 0);
    b2.ack_in = 2'b01;
    step();
    chk("tmo_late_ack", 32'(b2.ack_out), 1);
    b2.req_in = 1'b0;
    step();
    b2.ack_in = 2'b00;
    step();
    chk("tmo_done_ack", 32'(b2.ack_out), 0);
    chk("tmo_keep", 32'(b2.timeout), 1);

    // reset in HOLD, stale ack, then fresh store
    b2.req_in = 1'b1;
    step();
    b2.ack_in = 2'b01;
    step();
    chk("hold_ack", 32'(b2.ack_out), 1);
    rst = 1'b1;
    step();
    chk("mrst_req", 32'(b2.req_out), 0);
    chk("mrst_ack", 32'(b2.ack_out), 0);
    chk("mrst_sel", 32'(b2.sel_out), 0);
    chk("mrst_tmo", 32'(b2.timeout), 0);
    rst = 1'b0;
    b2.req_in = 1'b0;
    step();
    chk("stale_ack", 32'(b2.ack_out), 0);
    chk("stale_req", 32'(b2.req_out), 0);
    b2.ack_in = 2'b00;
    b2.req_in = 1'b1;
    step();
    chk("fr_req", 32'(b2.req_out), 1);
    step();
    chk("fr_wait", 32'(b2.ack_out), 0);
    b2.ack_in = 2'b01;
    step();
    chk("fr_ack", 32'(b2.ack_out), 1);
    b2.req_in = 1'b0;
    step();
    chk("fr_req0", 32'(b2.req_out), 0);
    b2.ack_in = 2'b00;
    step();
    chk("fr_ack0", 32'(b2.ack_out), 0);

    // random transactions on 3 channels with a duplicate entry
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 2);
      opc = (r == 0) ? ST : (r == 1) ? LD : 7'($urandom);
      m = ref_mask(opc);
      b3.opcode = opc;
      b3.req_in = 1'b1;
      b3.ack_in = 3'($urandom) & ~m;
      step();
      if (m == 3'b000) begin
        chk("r_err", 32'(b3.err_opc), 1);
        chk("r_eack", 32'(b3.ack_out), 1);
        chk("r_ereq", 32'(b3.req_out), 0);
        b3.opcode = 7'($urandom);
        step();
        chk("r_err_pulse", 32'(b3.err_opc), 0);
        chk("r_eack_hold", 32'(b3.ack_out), 1);
        b3.req_in = 1'b0;
        step();
        chk("r_eack_rtz", 32'(b3.ack_out), 0);
      end else begin
        chk("r_req", 32'(b3.req_out), 32'(m));
        chk("r_sel", 32'(b3.sel_out), 32'(m));
        chk("r_noerr", 32'(b3.err_opc), 0);
        chk("r_ack_lo", 32'(b3.ack_out), 0);
        d = $urandom_range(0, 3);
        for (int k = 0; k < d; k++) begin
          part = 3'($urandom) & m;
          if (part == m) part = 3'b000;
          nz = 3'($urandom) & ~m;
          b3.ack_in = part | nz;
          b3.opcode = 7'($urandom);
          step();
          chk("r_nojoin", 32'(b3.ack_out), 0);
          chk("r_req_hold", 32'(b3.req_out), 32'(m));
        end
        b3.ack_in = m | (3'($urandom) & ~m);
        step();
        chk("r_join", 32'(b3.ack_out), 1);
        b3.req_in = 1'b0;
        step();
        chk("r_rtz_req", 32'(b3.req_out), 0);
        chk("r_rtz_ack", 32'(b3.ack_out), 1);
        for (int k = 0; k < d; k++) begin
          b3.ack_in = m | (3'($urandom) & ~m);
          step();
          chk("r_rtz_wait", 32'(b3.ack_out), 1);
        end
        b3.ack_in = 3'($urandom) & ~m;
        step();
        chk("r_done_ack", 32'(b3.ack_out), 0);
        chk("r_done_sel", 32'(b3.sel_out), 0);
      end
      b3.ack_in = 3'b000;
      step();
      chk("r_idle_req", 32'(b3.req_out), 0);
      chk("r_idle_ack", 32'(b3.ack_out), 0);
      chk("r_idle_tmo", 32'(b3.timeout), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
